// File: rtl/serial_slave_responder_if.sv
// Bus bundle between a serial master and the slave responder.
// Handshake: the master's m_valid marks a header or payload bit, and it only counts while s_ready=1; s_valid marks a read-data bit with no backpressure.
interface serial_slave_responder_if;
  logic       slave_sel;
  logic       m_valid;
  logic       m_rw;
  logic       m_dout;
  logic       s_ready;
  logic       s_valid;
  logic       s_dout;
  logic       s_done;
  logic [2:0] s_state;

  modport master (
    output slave_sel, m_valid, m_rw, m_dout,
    input  s_ready, s_valid, s_dout, s_done, s_state
  );

  modport slave (
    input  slave_sel, m_valid, m_rw, m_dout,
    output s_ready, s_valid, s_dout, s_done, s_state
  );
endinterface

// File: rtl/serial_slave_responder.sv
// Serial slave with a small register-file memory: bit-serial address/write-data in,
// bit-serial read data out after a fixed latency, FSM state exported on s_state.
module serial_slave_responder #(
  parameter int ADDR_W       = 4,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  serial_slave_responder_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WDATA = 3'd2,
    S_RWAIT = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  localparam int MAX_AD = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int MAX_N  = (MAX_AD > READ_LATENCY) ? MAX_AD : READ_LATENCY;
  localparam int CNT_W  = $clog2(MAX_N + 1);
  localparam int DEPTH  = 1 << ADDR_W;

  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(READ_LATENCY - 1);

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   read_reg;
  logic                rw;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic [ADDR_W-1:0]   addr_mask, addr_nxt;
  logic [DATA_W-1:0]   data_mask, data_nxt, rd_shift;

  logic cnt_clr, cnt_inc, rw_load, addr_load, data_load, mem_we, rd_load;
  logic ready, valid, dout, done;

  // The incoming bit lands at position cnt; the merged value is used on the last
  // bit so the memory write and read-register load see the complete word.
  assign addr_mask = ADDR_W'(1) << cnt;
  assign addr_nxt  = (addr & ~addr_mask) | (bus.m_dout ? addr_mask : '0);
  assign data_mask = DATA_W'(1) << cnt;
  assign data_nxt  = (wdata & ~data_mask) | (bus.m_dout ? data_mask : '0);
  assign rd_shift  = read_reg >> cnt;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    rw_load   = 1'b0;
    addr_load = 1'b0;
    data_load = 1'b0;
    mem_we    = 1'b0;
    rd_load   = 1'b0;
    ready     = 1'b0;
    valid     = 1'b0;
    dout      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.slave_sel && bus.m_valid) begin
          rw_load   = 1'b1;
          cnt_clr   = 1'b1;
          state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
        ready = 1'b1;
        if (!bus.slave_sel) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.m_valid) begin
          addr_load = 1'b1;
          if (cnt == ADDR_LAST) begin
            cnt_clr   = 1'b1;
            rd_load   = !rw;
            state_nxt = rw ? S_WDATA : S_RWAIT;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_WDATA: begin
        ready = 1'b1;
        if (!bus.slave_sel) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (bus.m_valid) begin
          data_load = 1'b1;
          if (cnt == DATA_LAST) begin
            mem_we    = 1'b1;
            cnt_clr   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      S_RWAIT: begin
        if (!bus.slave_sel) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == LAT_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = S_RDATA;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_RDATA: begin
        valid = 1'b1;
        dout  = rd_shift[0];
        if (!bus.slave_sel) begin
          cnt_clr   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == DATA_LAST) begin
          cnt_clr   = 1'b1;
          state_nxt = S_DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        cnt_clr   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        cnt_clr   = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      addr     <= '0;
      wdata    <= '0;
      read_reg <= '0;
      rw       <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (cnt_clr)      cnt <= '0;
      else if (cnt_inc) cnt <= cnt + CNT_W'(1);
      if (rw_load)   rw       <= bus.m_rw;
      if (addr_load) addr     <= addr_nxt;
      if (data_load) wdata    <= data_nxt;
      if (mem_we)    mem[addr] <= data_nxt;
      if (rd_load)   read_reg <= mem[addr_nxt];
    end
  end

  assign bus.s_ready = ready;
  assign bus.s_valid = valid;
  assign bus.s_dout  = dout;
  assign bus.s_done  = done;
  assign bus.s_state = state;

endmodule

// File: tb/tb_serial_slave_responder.sv
// Self-checking bench for serial_slave_responder: directed vector table, hand-written
// stall/abort/reset/selection sequences, then random traffic against a memory model.
module tb_serial_slave_responder;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int LAT    = 2;
  localparam int BUDGET = 60;

  logic clk;
  logic reset;

  serial_slave_responder_if bus();

  serial_slave_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] mem_model [1 << ADDR_W];
  logic [DATA_W-1:0] exp_q [$];

  typedef struct {
    bit                rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                stall_at;
    int                stall_len;
    int                exp_cyc;
    logic [DATA_W-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.slave_sel = 1'b0;
    bus.m_valid   = 1'b0;
    bus.m_rw      = 1'b0;
    bus.m_dout    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = '0;
  endtask

  // Drives one full transaction; cycle 1 is the header cycle.
  task automatic do_txn(input bit rw, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int stall_at, input int stall_len,
                        output int done_cyc, output logic [DATA_W-1:0] rdata,
                        output int nvalid, output int nwait);
    int cyc;
    int nbits;
    logic [ADDR_W+DATA_W-1:0] bits;
    bits     = {d, a};
    nbits    = rw ? ADDR_W + DATA_W : ADDR_W;
    done_cyc = -1;
    rdata    = '0;
    nvalid   = 0;
    nwait    = 0;
    @(negedge clk);
    cyc = 1;
    bus.slave_sel = 1'b1;
    bus.m_valid   = 1'b1;
    bus.m_rw      = rw;
    bus.m_dout    = 1'($urandom);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          @(negedge clk);
          cyc++;
          if (k > 0) chk("stall_state", {29'd0, bus.s_state}, (i < ADDR_W) ? 1 : 2);
          bus.m_valid = 1'b0;
          bus.m_rw    = 1'($urandom);
          bus.m_dout  = 1'($urandom);
        end
      end
      @(negedge clk);
      cyc++;
      bus.m_valid = 1'b1;
      bus.m_dout  = bits[i];
    end
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      cyc++;
      bus.m_valid = 1'b0;
      bus.m_dout  = 1'b0;
      if (bus.s_valid) begin
        if (nvalid < DATA_W) rdata[nvalid] = bus.s_dout;
        nvalid++;
      end else begin
        if (bus.s_dout !== 1'b0) chk("dout_idle_zero", {31'd0, bus.s_dout}, 0);
        if (!bus.s_done && !bus.s_ready) nwait++;
      end
      if (bus.s_done) begin
        done_cyc = cyc;
        break;
      end
    end
    if (done_cyc < 0) chk("txn_timeout", 0, 1);
  endtask

  // Higher-level expectations: fixed lengths plus stalls, memory as a plain array.
  task automatic run_and_check(input string tag, input bit rw, input logic [ADDR_W-1:0] a,
                               input logic [DATA_W-1:0] d, input int stall_at, input int stall_len,
                               input int exp_cyc, input logic [DATA_W-1:0] exp_rd);
    int dc, nv, nw;
    logic [DATA_W-1:0] rd;
    do_txn(rw, a, d, stall_at, stall_len, dc, rd, nv, nw);
    chk({tag, "_len"}, dc, exp_cyc);
    if (rw) begin
      chk({tag, "_wr_novalid"}, nv, 0);
      mem_model[a] = d;
    end else begin
      exp_q.push_back(exp_rd);
      chk({tag, "_rd_bits"}, nv, DATA_W);
      chk({tag, "_rd_wait"}, nw, LAT);
      chk({tag, "_rd_data"}, {24'd0, rd}, {24'd0, exp_q.pop_front()});
    end
  endtask

  initial begin
    int dc, nv, nw;
    logic [DATA_W-1:0] rd;
    reset = 1'b1;
    idle_inputs();

    vecs[0] = '{rw: 0, addr: 4'h3, data: 8'h00, stall_at: -1, stall_len: 0, exp_cyc: 16, exp_rdata: 8'h00};
    vecs[1] = '{rw: 1, addr: 4'hA, data: 8'h5C, stall_at: -1, stall_len: 0, exp_cyc: 14, exp_rdata: 8'h00};
    vecs[2] = '{rw: 0, addr: 4'hA, data: 8'h00, stall_at: -1, stall_len: 0, exp_cyc: 16, exp_rdata: 8'h5C};
    vecs[3] = '{rw: 1, addr: 4'h1, data: 8'hFF, stall_at: 2,  stall_len: 3, exp_cyc: 17, exp_rdata: 8'h00};
    vecs[4] = '{rw: 0, addr: 4'h1, data: 8'h00, stall_at: 1,  stall_len: 2, exp_cyc: 18, exp_rdata: 8'hFF};
    vecs[5] = '{rw: 1, addr: 4'hF, data: 8'h81, stall_at: 10, stall_len: 2, exp_cyc: 16, exp_rdata: 8'h00};
    vecs[6] = '{rw: 0, addr: 4'hF, data: 8'h00, stall_at: -1, stall_len: 0, exp_cyc: 16, exp_rdata: 8'h81};

    do_reset();
    chk("reset_ready", {31'd0, bus.s_ready}, 1);
    chk("reset_valid", {31'd0, bus.s_valid}, 0);
    chk("reset_dout",  {31'd0, bus.s_dout},  0);
    chk("reset_done",  {31'd0, bus.s_done},  0);
    chk("reset_state", {29'd0, bus.s_state}, 0);

    for (int i = 0; i < 7; i++)
      run_and_check($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].data,
                    vecs[i].stall_at, vecs[i].stall_len, vecs[i].exp_cyc, vecs[i].exp_rdata);

    // selection: m_valid without slave_sel is ignored in IDLE
    @(negedge clk);
    bus.slave_sel = 1'b0;
    bus.m_valid   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.m_rw   = 1'($urandom);
      bus.m_dout = 1'($urandom);
      @(negedge clk);
      chk("unsel_outputs", {24'd0, bus.s_state, bus.s_ready, bus.s_valid, bus.s_dout, bus.s_done}, 32'h08);
    end
    idle_inputs();

    // abort: slave_sel drops after 5 write-data bits
    @(negedge clk);
    bus.slave_sel = 1'b1;
    bus.m_valid   = 1'b1;
    bus.m_rw      = 1'b1;
    for (int i = 0; i < ADDR_W + 5; i++) begin
      @(negedge clk);
      bus.m_dout = (i < ADDR_W) ? ((4'h2 >> i) & 1'b1) : 1'b1;
    end
    @(negedge clk);
    chk("abort_in_wdata", {29'd0, bus.s_state}, 2);
    bus.slave_sel = 1'b0;
    bus.m_valid   = 1'b0;
    @(negedge clk);
    chk("abort_idle",   {29'd0, bus.s_state}, 0);
    chk("abort_nodone", {31'd0, bus.s_done},  0);
    idle_inputs();
    run_and_check("abort_rd", 1'b0, 4'h2, 8'h00, -1, 0, 16, mem_model[2]);

    // reset during RDATA bit 3
    do_txn(1'b1, 4'h6, 8'hC3, -1, 0, dc, rd, nv, nw);
    mem_model[6] = 8'hC3;
    @(negedge clk);
    bus.slave_sel = 1'b1;
    bus.m_valid   = 1'b1;
    bus.m_rw      = 1'b0;
    for (int i = 0; i < ADDR_W; i++) begin
      @(negedge clk);
      bus.m_dout = (4'h6 >> i) & 1'b1;
    end
    nv = 0;
    for (int k = 0; k < BUDGET; k++) begin
      @(negedge clk);
      bus.m_valid = 1'b0;
      if (bus.s_valid) begin
        if (nv == 3) begin
          chk("rst_bit3_dout", {31'd0, bus.s_dout}, {31'd0, mem_model[6][3]});
          reset = 1'b1;
          break;
        end
        nv++;
      end
      if (k == BUDGET - 1) chk("rst_rdata_timeout", 0, 1);
    end
    @(negedge clk);
    chk("rst_mid_valid", {31'd0, bus.s_valid}, 0);
    chk("rst_mid_state", {29'd0, bus.s_state}, 0);
    chk("rst_mid_ready", {31'd0, bus.s_ready}, 1);
    reset = 1'b0;
    idle_inputs();
    for (int i = 0; i < (1 << ADDR_W); i++) mem_model[i] = '0;
    run_and_check("post_rst_rd", 1'b0, 4'h6, 8'h00, -1, 0, 16, mem_model[6]);

    // random traffic against the memory model
    for (int t = 0; t < 40; t++) begin
      bit rw;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      int sa, sl, nb;
      rw = 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      d  = DATA_W'($urandom);
      nb = rw ? ADDR_W + DATA_W : ADDR_W;
      sa = -1;
      sl = 0;
      if ($urandom_range(0, 2) == 0) begin
        sa = $urandom_range(0, nb - 1);
        sl = $urandom_range(1, 3);
      end
      run_and_check("rand", rw, a, d, sa, sl,
                    (rw ? 1 + ADDR_W + DATA_W + 1 : 1 + ADDR_W + LAT + DATA_W + 1) + sl,
                    mem_model[a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
